sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO for buffering AXI/AHB side-band fields (size, burst, ID, data) inside the bridge where both sides share one clock. Data width, depth and programmable thresholds are configurable. A read mode parameter selects registered output or first-word-fall-through. It also provides an occupancy count, almost-full/almost-empty flags, overflow/underflow error pulses and a synchronous flush.

Parameters:
DATA_WIDTH, 3, width of data_in/data_out in bits (>=1)
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (>=1)
AFULL_LEVEL, 12, almost_full asserts when count >= AFULL_LEVEL (1..DEPTH)
AEMPTY_LEVEL, 2, almost_empty asserts when count <= AEMPTY_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = registered read data (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  input  1  single clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO state
data_in  input  DATA_WIDTH  write data
write_en  input  1  write request
read_en  input  1  read request
data_out  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_LEVEL
almost_empty  output  1  count <= AEMPTY_LEVEL
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected because full
underflow  output  1  one-cycle pulse: read rejected because empty

Behaviour:
- Reset (resetn low, async): wr_ptr, rd_ptr, count = 0; data_out = 0; overflow = underflow = 0; therefore empty = 1, almost_empty = 1, full = 0, almost_full = 0. RAM is not reset; contents are undefined until written.
- Pointers: ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits index RAM. Pointers increment modulo 2**(ADDR_WIDTH+1), giving natural wrap.
- count register: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither. full, empty, almost_full and almost_empty are decoded from the count register, so they are glitch-free and change the cycle after the causing edge.
- Write accepted: write_en && !full. RAM[wr_ptr] <= data_in; wr_ptr++.
- Read accepted: read_en && !empty. rd_ptr++.
- Acceptance uses the pre-edge full/empty only. There is no pass-through:
  - When full with write_en and read_en both high: the read is accepted, the write is rejected, and overflow pulses.
  - When empty with both high: the write is accepted, the read is rejected, and underflow pulses.
- overflow / underflow: registered. High for exactly the one cycle after a rejected request. Consecutive rejected requests give continuous high.
- FWFT=0: on an accepted read, data_out <= RAM[rd_ptr] at that edge, so data is valid the cycle after the read. Otherwise data_out holds its last value.
- FWFT=1: data_out = RAM[rd_ptr] combinationally when !empty, else 0. An accepted read consumes the displayed word, and the next word is visible after the edge.
- flush (synchronous, priority over read/write in the same cycle): pointers, count, overflow and underflow clear to 0; data_out clears to 0; RAM is untouched. The write and read in the flush cycle are ignored and flagged as neither overflow nor underflow.
- Reset asserted mid-operation: all state clears immediately; earlier contents are lost.
- Parameter legality (AFULL_LEVEL <= DEPTH, AEMPTY_LEVEL < DEPTH) is checked by a simulation-only initial assertion.

Test Plan:
- Reset then idle, default params -> empty=1, almost_empty=1, full=0, count=0, data_out=0, no error pulses.
- FWFT=0: write 3'd1..3'd5 on consecutive cycles, then read 5 -> count steps 1..5 then 4..0; data_out shows 1..5, each one cycle after its read; almost_empty deasserts when count=3 and reasserts at count=2.
- Fill 16 entries, then write_en=1 with data 3'd7 while full -> full=1, count=16, overflow high one cycle, 3'd7 never read back. almost_full is high from count=12.
- Full plus simultaneous read/write for 1 cycle -> count=15, overflow pulse, first entry output. Empty plus simultaneous read/write -> count=1, underflow pulse, written word later read intact.
- Wrap: 40 interleaved write/read pairs with an incrementing pattern, pointers crossing 32 -> read sequence equals write sequence, count never exceeds 1, no error pulses.
- FWFT=1, DATA_WIDTH=8: write 8'hA5 -> data_out=8'hA5 next cycle without read_en. Then flush with write_en=1 -> count=0, empty=1, data_out=0, no overflow.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a FIFO user (master) and sync_fifo_param (slave).
interface sync_fifo_param_if #(
    parameter int unsigned DATA_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  flush;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, data_in, write_en, read_en,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, data_in, write_en, read_en,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, threshold flags, error pulses and synchronous flush.
// FWFT selects registered read data (0) or first-word-fall-through (1).
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH   = 3,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned AFULL_LEVEL  = 12,
    parameter int unsigned AEMPTY_LEVEL = 2,
    parameter int unsigned FWFT         = 0
) (
    input  logic              clk,
    input  logic              resetn,
    sync_fifo_param_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  wr_acc_c, rd_acc_c;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Acceptance looks only at pre-edge flags; flush swallows both requests.
    assign wr_acc_c = bus.write_en && !full_q  && !bus.flush;
    assign rd_acc_c = bus.read_en  && !empty_q && !bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
        if (!bus.flush) begin
            if (wr_acc_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_acc_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (wr_acc_c && !rd_acc_c) count_d = count_q + PTR_W'(1);
            if (rd_acc_c && !wr_acc_c) count_d = count_q - PTR_W'(1);
            ovf_d = bus.write_en && full_q;
            udf_d = bus.read_en  && empty_q;
        end else begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        full_d   = (count_d == PTR_W'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= PTR_W'(AFULL_LEVEL));
        aempty_d = (count_d <= PTR_W'(AEMPTY_LEVEL));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.data_in;
    end

    if (FWFT == 0) begin : g_reg_out
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (bus.flush)     dout_d = '0;
            else if (rd_acc_c) dout_d = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) dout_q <= '0;
            else         dout_q <= dout_d;
        end

        assign bus.data_out = dout_q;
    end else begin : g_fwft_out
        // Head word is shown as soon as the FIFO is non-empty.
        assign bus.data_out = empty_q ? '0 : mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

`ifndef SYNTHESIS
    initial begin : param_check
        assert (AFULL_LEVEL >= 1 && AFULL_LEVEL <= DEPTH);
        assert (AEMPTY_LEVEL < DEPTH);
    end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-output 3-bit FIFO and an FWFT 8-bit FIFO driven in lockstep.
module tb_sync_fifo_param;
    logic clk;
    logic resetn;

    sync_fifo_param_if #(.DATA_WIDTH(3), .ADDR_WIDTH(4)) if0 ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();

    sync_fifo_param #(.DATA_WIDTH(3), .ADDR_WIDTH(4), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2), .FWFT(0))
        u_dut0 (.clk(clk), .resetn(resetn), .bus(if0));
    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2), .FWFT(1))
        u_dut1 (.clk(clk), .resetn(resetn), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference: plain queues holding the FIFO contents.
    logic [2:0] q0[$];
    logic [7:0] q1[$];
    logic [2:0] dout0_m;
    logic       ovf0_m, udf0_m, ovf1_m, udf1_m;

    typedef struct {
        logic       we;
        logic       re;
        logic [2:0] din;
        logic [4:0] cnt;
        logic [2:0] dout;
        logic [5:0] flags;   // {full, empty, afull, aempty, ovf, udf}
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        dout0_m = '0;
        ovf0_m = 1'b0; udf0_m = 1'b0; ovf1_m = 1'b0; udf1_m = 1'b0;
    endtask

    task automatic model_step(input logic fl, input logic we, input logic re, input logic [7:0] d);
        bit f0, e0, f1, e1;
        logic [7:0] junk;
        if (fl) begin
            model_clear();
        end else begin
            f0 = (q0.size() == 16); e0 = (q0.size() == 0);
            f1 = (q1.size() == 16); e1 = (q1.size() == 0);
            ovf0_m = we && f0; udf0_m = re && e0;
            ovf1_m = we && f1; udf1_m = re && e1;
            if (re && !e0) dout0_m = q0.pop_front();
            if (we && !f0) q0.push_back(d[2:0]);
            if (re && !e1) junk = q1.pop_front();
            if (we && !f1) q1.push_back(d);
        end
    endtask

    task automatic check_model();
        int n0, n1;
        logic [7:0] head1;
        n0 = q0.size();
        n1 = q1.size();
        head1 = (n1 > 0) ? q1[0] : 8'h00;
        chk("m0_count", 32'(if0.count), 32'(n0));
        chk("m0_dout", 32'(if0.data_out), 32'(dout0_m));
        chk("m0_flags",
            32'({if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow}),
            32'({n0 == 16, n0 == 0, n0 >= 12, n0 <= 2, ovf0_m, udf0_m}));
        chk("m1_count", 32'(if1.count), 32'(n1));
        chk("m1_dout", 32'(if1.data_out), 32'(head1));
        chk("m1_flags",
            32'({if1.full, if1.empty, if1.almost_full, if1.almost_empty, if1.overflow, if1.underflow}),
            32'({n1 == 16, n1 == 0, n1 >= 12, n1 <= 2, ovf1_m, udf1_m}));
    endtask

    // One clock: drive both FIFOs, advance the model, check after the edge.
    task automatic cyc(input logic fl, input logic we, input logic re, input logic [7:0] d);
        if0.flush = fl; if0.write_en = we; if0.read_en = re; if0.data_in = d[2:0];
        if1.flush = fl; if1.write_en = we; if1.read_en = re; if1.data_in = d;
        @(posedge clk);
        model_step(fl, we, re, d);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        if0.flush = 0; if0.write_en = 0; if0.read_en = 0; if0.data_in = '0;
        if1.flush = 0; if1.write_en = 0; if1.read_en = 0; if1.data_in = '0;
        resetn = 1'b0;
        #2;
        model_clear();
        check_model();
        @(posedge clk);
        #1;
        check_model();
        resetn = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{we:1, re:0, din:3'd1, cnt:5'd1, dout:3'd0, flags:6'b000100};
        vecs[1]  = '{we:1, re:0, din:3'd2, cnt:5'd2, dout:3'd0, flags:6'b000100};
        vecs[2]  = '{we:1, re:0, din:3'd3, cnt:5'd3, dout:3'd0, flags:6'b000000};
        vecs[3]  = '{we:1, re:0, din:3'd4, cnt:5'd4, dout:3'd0, flags:6'b000000};
        vecs[4]  = '{we:1, re:0, din:3'd5, cnt:5'd5, dout:3'd0, flags:6'b000000};
        vecs[5]  = '{we:0, re:1, din:3'd0, cnt:5'd4, dout:3'd1, flags:6'b000000};
        vecs[6]  = '{we:0, re:1, din:3'd0, cnt:5'd3, dout:3'd2, flags:6'b000000};
        vecs[7]  = '{we:0, re:1, din:3'd0, cnt:5'd2, dout:3'd3, flags:6'b000100};
        vecs[8]  = '{we:0, re:1, din:3'd0, cnt:5'd1, dout:3'd4, flags:6'b000100};
        vecs[9]  = '{we:0, re:1, din:3'd0, cnt:5'd0, dout:3'd5, flags:6'b010100};
        vecs[10] = '{we:0, re:1, din:3'd0, cnt:5'd0, dout:3'd5, flags:6'b010101};
        vecs[11] = '{we:0, re:0, din:3'd0, cnt:5'd0, dout:3'd5, flags:6'b010100};

        model_clear();
        resetn = 1'b0;
        if0.flush = 0; if0.write_en = 0; if0.read_en = 0; if0.data_in = '0;
        if1.flush = 0; if1.write_en = 0; if1.read_en = 0; if1.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("rst_empty", 32'(if0.empty), 32'd1);
        chk("rst_dout", 32'(if0.data_out), 32'd0);
        resetn = 1'b1;
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);

        // Directed table: five writes then reads past empty.
        for (int i = 0; i < 12; i++) begin
            cyc(0, vecs[i].we, vecs[i].re, {5'b0, vecs[i].din});
            chk("vec_count", 32'(if0.count), 32'(vecs[i].cnt));
            chk("vec_dout", 32'(if0.data_out), 32'(vecs[i].dout));
            chk("vec_flags",
                32'({if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow}),
                32'(vecs[i].flags));
        end

        // Fill to full, then a rejected write of 7.
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, 8'(i % 7));
            chk("fill_count", 32'(if0.count), 32'(i + 1));
            chk("fill_afull", 32'(if0.almost_full), 32'((i + 1) >= 12));
        end
        cyc(0, 1, 0, 8'd7);
        chk("ovf_pulse", 32'(if0.overflow), 32'd1);
        chk("ovf_count", 32'(if0.count), 32'd16);
        chk("ovf_full", 32'(if0.full), 32'd1);
        cyc(0, 0, 0, 8'd0);
        chk("ovf_clear", 32'(if0.overflow), 32'd0);

        // Full with read and write together: read wins, write flagged.
        cyc(0, 1, 1, 8'd7);
        chk("fullrw_count", 32'(if0.count), 32'd15);
        chk("fullrw_ovf", 32'(if0.overflow), 32'd1);
        chk("fullrw_dout", 32'(if0.data_out), 32'd0);
        for (int i = 1; i < 16; i++) begin
            cyc(0, 0, 1, 8'd0);
            chk("drain_dout", 32'(if0.data_out), 32'(i % 7));
        end
        chk("drain_empty", 32'(if0.empty), 32'd1);

        // Empty with read and write together: write wins, read flagged.
        cyc(0, 1, 1, 8'd3);
        chk("emptyrw_count", 32'(if0.count), 32'd1);
        chk("emptyrw_udf", 32'(if0.underflow), 32'd1);
        cyc(0, 0, 1, 8'd0);
        chk("emptyrw_dout", 32'(if0.data_out), 32'd3);
        chk("emptyrw_udf_clr", 32'(if0.underflow), 32'd0);

        // Interleaved pairs carry the pointers past 32.
        for (int k = 0; k < 40; k++) begin
            cyc(0, 1, 0, 8'(k));
            cyc(0, 0, 1, 8'd0);
            chk("wrap_dout", 32'(if0.data_out), 32'(k % 8));
            chk("wrap_err", 32'({if0.overflow, if0.underflow}), 32'd0);
        end

        // FWFT view, then flush with a concurrent write.
        cyc(0, 1, 0, 8'hA5);
        chk("fwft_dout", 32'(if1.data_out), 32'hA5);
        cyc(1, 1, 0, 8'h11);
        chk("flush_count", 32'(if1.count), 32'd0);
        chk("flush_empty", 32'(if1.empty), 32'd1);
        chk("flush_dout1", 32'(if1.data_out), 32'd0);
        chk("flush_ovf", 32'(if1.overflow), 32'd0);
        chk("flush_dout0", 32'(if0.data_out), 32'd0);

        // Asynchronous reset in the middle of traffic.
        cyc(0, 1, 0, 8'h21);
        cyc(0, 1, 0, 8'h42);
        cyc(0, 1, 1, 8'h63);
        do_reset();
        chk("midrst_count", 32'(if0.count), 32'd0);

        // Randomised traffic with alternating fill/drain bias.
        for (int i = 0; i < 600; i++) begin
            int  wp;
            logic fl, we, re;
            wp = ((i / 100) % 2 == 0) ? 70 : 30;
            fl = ($urandom_range(0, 63) == 0);
            we = ($urandom_range(0, 99) < wp);
            re = ($urandom_range(0, 99) < (100 - wp));
            cyc(fl, we, re, 8'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
